joy_snoop_multi: RTL and testbench



---
 rtl/joy_snoop_multi_if.sv | 23 ++
 rtl/joy_snoop_multi.sv | 104 ++++++++++
 tb/tb_joy_snoop_multi.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/joy_snoop_multi_if.sv
// Bus bundle for the controller-port snooper.
//   cpu_addr  : CPU address bus (16 bits)
//   cpu_data  : CPU data bit D0
//   cpu_rw    : 1 = read, 0 = write
//   joy       : published reports, port p in [p*REPORT_BITS +: REPORT_BITS]
//   joy_valid : per-port one-cycle pulse marking a newly published report
// The master modport is the CPU-bus side that drives cpu_* and observes
// the reports. The slave modport is the snooper itself.
interface joy_snoop_multi_if #(
    parameter int NUM_PORTS   = 1,
    parameter int REPORT_BITS = 8
);
    logic [15:0]                        cpu_addr;
    logic                               cpu_data;
    logic                               cpu_rw;
    logic [NUM_PORTS*REPORT_BITS-1:0]   joy;
    logic [NUM_PORTS-1:0]               joy_valid;

    modport master (output cpu_addr, output cpu_data, output cpu_rw,
                    input joy, input joy_valid);
    modport slave  (input cpu_addr, input cpu_data, input cpu_rw,
                    output joy, output joy_valid);
endinterface

// File: rtl/joy_snoop_multi.sv
// Passive controller-port snooper. It watches $4016 strobe writes and
// $4016/$4017 serial reads on the CPU bus, reassembles each port's report
// (first bit read lands in the MSB), and publishes it with a one-cycle
// valid pulse. With CONFIRM=1 a frame is only published when it matches
// the previous complete frame on the same port, which filters out frames
// corrupted by DMC DMA double reads.
// Ports:
//   m2   : CPU M2, the only clock; all state changes on its falling edge
//   rst  : asynchronous, active-high reset
//   bus  : joy_snoop_multi_if.slave (cpu_addr, cpu_data, cpu_rw in;
//          joy, joy_valid out)
module joy_snoop_multi #(
    parameter int NUM_PORTS   = 1,
    parameter int REPORT_BITS = 8,
    parameter int CONFIRM     = 0
) (
    input  logic                m2,
    input  logic                rst,
    joy_snoop_multi_if.slave    bus
);
    localparam int CW = $clog2(REPORT_BITS + 1);
    localparam int SW = REPORT_BITS - 1;

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT} state_t;

    state_t                 st_q       [NUM_PORTS];
    logic [CW-1:0]          cnt_q      [NUM_PORTS];
    logic [SW-1:0]          sh_q       [NUM_PORTS];
    logic [REPORT_BITS-1:0] joy_q      [NUM_PORTS];
    logic [REPORT_BITS-1:0] cand_q     [NUM_PORTS];
    logic [REPORT_BITS-1:0] frame_d    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   cand_vld_q;
    logic [NUM_PORTS-1:0]   vld_q;
    logic [NUM_PORTS-1:0]   rd_port;
    logic                   strobe_q;

    logic wr_4016;
    logic strobe_set;
    logic strobe_fall;

    // $4017 writes belong to the APU frame counter, so only $4016 matters.
    assign wr_4016     = !bus.cpu_rw && (bus.cpu_addr == 16'h4016);
    assign strobe_set  = wr_4016 && bus.cpu_data;
    assign strobe_fall = wr_4016 && !bus.cpu_data && strobe_q;

    always_comb begin
        rd_port = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_port[p] = bus.cpu_rw && (bus.cpu_addr == 16'h4016 + 16'(p));
            frame_d[p] = {sh_q[p], bus.cpu_data};
        end
    end

    always_ff @(negedge m2 or posedge rst) begin
        if (rst) begin
            strobe_q   <= 1'b0;
            vld_q      <= '0;
            cand_vld_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                st_q[p]   <= IDLE;
                cnt_q[p]  <= '0;
                sh_q[p]   <= '0;
                joy_q[p]  <= '0;
                cand_q[p] <= '0;
            end
        end else begin
            if (wr_4016) strobe_q <= bus.cpu_data;
            vld_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (strobe_set) begin
                    // Strobe restarts every port and drops any partial frame.
                    st_q[p]  <= LATCH;
                    cnt_q[p] <= '0;
                    sh_q[p]  <= '0;
                end else if (st_q[p] == LATCH && strobe_fall) begin
                    st_q[p] <= SHIFT;
                end else if (st_q[p] == SHIFT && rd_port[p]) begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                    if (cnt_q[p] == CW'(REPORT_BITS - 1)) begin
                        st_q[p] <= IDLE;
                        if (CONFIRM == 0 ||
                            (cand_vld_q[p] && frame_d[p] == cand_q[p])) begin
                            joy_q[p] <= frame_d[p];
                            vld_q[p] <= 1'b1;
                        end
                        cand_q[p]     <= frame_d[p];
                        cand_vld_q[p] <= 1'b1;
                    end else begin
                        sh_q[p] <= {sh_q[p][SW-2:0], bus.cpu_data};
                    end
                end
            end
        end
    end

    always_comb begin
        bus.joy = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.joy[p*REPORT_BITS +: REPORT_BITS] = joy_q[p];
        end
    end

    assign bus.joy_valid = vld_q;
endmodule

// File: tb/tb_joy_snoop_multi.sv
// Bench for joy_snoop_multi. Three instances cover the configurations:
//   A: 1 port, 8 bits, no confirm
//   B: 2 ports, 8 bits, no confirm
//   C: 1 port, 24 bits, confirm
// Each instance has its own bus; expected publishes are queued when a
// frame is driven and popped whenever the instance pulses joy_valid.
module tb_joy_snoop_multi;
    logic m2 = 1'b0;
    logic rst = 1'b1;

    always #5 m2 = ~m2;

    logic [15:0] b_addr [3];
    logic        b_rw   [3];
    logic        b_dat  [3];

    joy_snoop_multi_if #(.NUM_PORTS(1), .REPORT_BITS(8))  ifa ();
    joy_snoop_multi_if #(.NUM_PORTS(2), .REPORT_BITS(8))  ifb ();
    joy_snoop_multi_if #(.NUM_PORTS(1), .REPORT_BITS(24)) ifc ();

    assign ifa.cpu_addr = b_addr[0];
    assign ifa.cpu_rw   = b_rw[0];
    assign ifa.cpu_data = b_dat[0];
    assign ifb.cpu_addr = b_addr[1];
    assign ifb.cpu_rw   = b_rw[1];
    assign ifb.cpu_data = b_dat[1];
    assign ifc.cpu_addr = b_addr[2];
    assign ifc.cpu_rw   = b_rw[2];
    assign ifc.cpu_data = b_dat[2];

    joy_snoop_multi #(.NUM_PORTS(1), .REPORT_BITS(8), .CONFIRM(0))
        dut_a (.m2(m2), .rst(rst), .bus(ifa.slave));
    joy_snoop_multi #(.NUM_PORTS(2), .REPORT_BITS(8), .CONFIRM(0))
        dut_b (.m2(m2), .rst(rst), .bus(ifb.slave));
    joy_snoop_multi #(.NUM_PORTS(1), .REPORT_BITS(24), .CONFIRM(1))
        dut_c (.m2(m2), .rst(rst), .bus(ifc.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb0[$];
    logic [31:0] qb1[$];
    logic [31:0] qc[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive after the rising edge, DUT samples on the
    // falling edge, then the bus returns to an idle read of $0000.
    task automatic cyc(input int s, input logic [15:0] a, input logic rw,
                       input logic d);
        @(posedge m2);
        #1;
        b_addr[s] = a;
        b_rw[s]   = rw;
        b_dat[s]  = d;
        @(negedge m2);
        #2;
        b_addr[s] = 16'h0000;
        b_rw[s]   = 1'b1;
        b_dat[s]  = 1'b0;
    endtask

    task automatic strobe(input int s);
        cyc(s, 16'h4016, 1'b0, 1'b1);
        cyc(s, 16'h4016, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int s, input logic [15:0] a,
                              input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(s, a, 1'b1, v[i]);
    endtask

    // Monitor: every valid pulse must match the next queued expectation.
    logic [31:0] e_mon;
    always @(negedge m2) begin
        #1;
        if (ifa.joy_valid[0]) begin
            if (qa.size() == 0) check("A_unexpected_valid", 1, 0);
            else begin e_mon = qa.pop_front(); check("A_joy", ifa.joy, e_mon); end
        end
        if (ifb.joy_valid[0]) begin
            if (qb0.size() == 0) check("B0_unexpected_valid", 1, 0);
            else begin e_mon = qb0.pop_front(); check("B0_joy", ifb.joy[7:0], e_mon); end
        end
        if (ifb.joy_valid[1]) begin
            if (qb1.size() == 0) check("B1_unexpected_valid", 1, 0);
            else begin e_mon = qb1.pop_front(); check("B1_joy", ifb.joy[15:8], e_mon); end
        end
        if (ifc.joy_valid[0]) begin
            if (qc.size() == 0) check("C_unexpected_valid", 1, 0);
            else begin e_mon = qc.pop_front(); check("C_joy", ifc.joy, e_mon); end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            b_addr[s] = 16'h0000;
            b_rw[s]   = 1'b1;
            b_dat[s]  = 1'b0;
        end
        repeat (3) @(posedge m2);
        #2;
        check("rst_joy_a", ifa.joy, 0);
        check("rst_vld_a", ifa.joy_valid, 0);
        check("rst_joy_b", ifb.joy, 0);
        check("rst_joy_c", ifc.joy, 0);
        rst = 1'b0;

        // Reads without a strobe are never captured.
        send_frame(0, 16'h4016, 32'hFF, 8);
        check("nostrobe_joy_a", ifa.joy, 0);

        // Standard pad frame, then one extra read that must be ignored.
        strobe(0);
        qa.push_back(32'h91);
        send_frame(0, 16'h4016, 32'h91, 8);
        cyc(0, 16'h4016, 1'b1, 1'b1);
        check("extra_read_joy_a", ifa.joy, 8'h91);

        // Strobe mid-frame discards the partial frame.
        strobe(0);
        send_frame(0, 16'h4016, 32'h00, 5);
        strobe(0);
        qa.push_back(32'hFF);
        send_frame(0, 16'h4016, 32'hFF, 8);
        check("restrobe_joy_a", ifa.joy, 8'hFF);

        // Two ports, interleaved; a $4017 write is not a strobe.
        strobe(1);
        cyc(1, 16'h4017, 1'b0, 1'b1);
        qb0.push_back(32'hA5);
        qb1.push_back(32'h3C);
        begin
            logic [7:0] va;
            logic [7:0] vb;
            va = 8'hA5;
            vb = 8'h3C;
            for (int i = 7; i >= 0; i--) begin
                cyc(1, 16'h4016, 1'b1, va[i]);
                cyc(1, 16'h4017, 1'b1, vb[i]);
            end
        end
        check("two_port_joy_b", ifb.joy, 16'h3CA5);

        // Confirm mode: publish only on a repeated frame.
        strobe(2);
        send_frame(2, 16'h4016, 32'h123456, 24);
        strobe(2);
        send_frame(2, 16'h4016, 32'h123457, 24);
        check("confirm_nopub_c", ifc.joy, 0);
        strobe(2);
        qc.push_back(32'h123457);
        send_frame(2, 16'h4016, 32'h123457, 24);
        check("confirm_pub_c", ifc.joy, 24'h123457);

        // Asynchronous reset in the middle of a frame.
        strobe(0);
        send_frame(0, 16'h4016, 32'hF, 4);
        @(posedge m2);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_joy_a", ifa.joy, 0);
        check("midrst_joy_b", ifb.joy, 0);
        check("midrst_joy_c", ifc.joy, 0);
        check("midrst_vld_a", ifa.joy_valid, 0);
        #3;
        rst = 1'b0;
        send_frame(0, 16'h4016, 32'hF, 4);
        check("postrst_joy_a", ifa.joy, 0);

        // Candidate was cleared by reset, so a single frame cannot publish.
        strobe(2);
        send_frame(2, 16'h4016, 32'h123457, 24);
        check("postrst_confirm_c", ifc.joy, 0);

        repeat (3) @(posedge m2);
        check("qa_drained", qa.size(), 0);
        check("qb0_drained", qb0.size(), 0);
        check("qb1_drained", qb1.size(), 0);
        check("qc_drained", qc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
